// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner and its emulator:
// row/column line patterns, key code map, emulator state encoding and
// the key-code to row/column decode.
package keypad_pkg;

    // Active-low one-hot row drive patterns (scanner -> keypad)
    localparam logic [3:0] ROW0 = 4'b0111;
    localparam logic [3:0] ROW1 = 4'b1011;
    localparam logic [3:0] ROW2 = 4'b1101;
    localparam logic [3:0] ROW3 = 4'b1110;

    // Active-low one-hot column sense patterns (keypad -> scanner)
    localparam logic [3:0] COL0 = 4'b0111;
    localparam logic [3:0] COL1 = 4'b1011;
    localparam logic [3:0] COL2 = 4'b1101;
    localparam logic [3:0] COL3 = 4'b1110;

    // Released lines: nothing pulled low
    localparam logic [3:0] IDLE_LINES = 4'hF;

    // Bounce LFSR reset seed
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Key codes as reported by the scanner
    typedef enum logic [3:0] {
        KEY_0 = 4'h0, KEY_1 = 4'h1, KEY_2 = 4'h2, KEY_3 = 4'h3,
        KEY_4 = 4'h4, KEY_5 = 4'h5, KEY_6 = 4'h6, KEY_7 = 4'h7,
        KEY_8 = 4'h8, KEY_9 = 4'h9, KEY_A = 4'hA, KEY_B = 4'hB,
        KEY_C = 4'hC, KEY_D = 4'hD, KEY_E = 4'hE, KEY_F = 4'hF
    } key_code_t;

    // Emulator press sequencing states
    typedef enum logic [2:0] {
        EMU_IDLE       = 3'd0,
        EMU_BOUNCE_IN  = 3'd1,
        EMU_HOLD       = 3'd2,
        EMU_BOUNCE_OUT = 3'd3,
        EMU_GAP        = 3'd4
    } emu_state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } rowcol_t;

    // Physical position of each key on the membrane
    function automatic rowcol_t key_to_rowcol(input logic [3:0] code);
        rowcol_t rc;
        rc = '{row: 2'd0, col: 2'd0};
        case (code)
            KEY_1: rc = '{row: 2'd0, col: 2'd0};
            KEY_2: rc = '{row: 2'd0, col: 2'd1};
            KEY_3: rc = '{row: 2'd0, col: 2'd2};
            KEY_A: rc = '{row: 2'd0, col: 2'd3};
            KEY_4: rc = '{row: 2'd1, col: 2'd0};
            KEY_5: rc = '{row: 2'd1, col: 2'd1};
            KEY_6: rc = '{row: 2'd1, col: 2'd2};
            KEY_B: rc = '{row: 2'd1, col: 2'd3};
            KEY_7: rc = '{row: 2'd2, col: 2'd0};
            KEY_8: rc = '{row: 2'd2, col: 2'd1};
            KEY_9: rc = '{row: 2'd2, col: 2'd2};
            KEY_C: rc = '{row: 2'd2, col: 2'd3};
            KEY_E: rc = '{row: 2'd3, col: 2'd0};
            KEY_0: rc = '{row: 2'd3, col: 2'd1};
            KEY_F: rc = '{row: 2'd3, col: 2'd2};
            KEY_D: rc = '{row: 2'd3, col: 2'd3};
            default: rc = '{row: 2'd0, col: 2'd0};
        endcase
        return rc;
    endfunction

    function automatic logic [3:0] row_pattern(input logic [1:0] row);
        logic [3:0] p;
        case (row)
            2'd0:    p = ROW0;
            2'd1:    p = ROW1;
            2'd2:    p = ROW2;
            default: p = ROW3;
        endcase
        return p;
    endfunction

    function automatic logic [3:0] col_pattern(input logic [1:0] col);
        logic [3:0] p;
        case (col)
            2'd0:    p = COL0;
            2'd1:    p = COL1;
            2'd2:    p = COL2;
            default: p = COL3;
        endcase
        return p;
    endfunction

    // Terminal count for a phase of n cycles; n == 0 still lasts one cycle
    function automatic int last_index(input int n);
        return (n == 0) ? 0 : n - 1;
    endfunction

endpackage

// File: rtl/lfsr8_bounce.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) producing the pseudo-random
// contact level during bounce windows. Exists only when the bounce
// feature is built in (KEYPAD_EMU_BOUNCE_EN).
`ifdef KEYPAD_EMU_BOUNCE_EN
module lfsr8_bounce (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] seed,
    output logic       bit_out
);

    logic [7:0] lfsr_q;

    // Reload the seed on reset, otherwise shift only while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= seed;
        end else if (en) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign bit_out = lfsr_q[7];

endmodule
`endif

// File: rtl/keypad_matrix_emulator.sv
// Emulates a 4x4 active-low membrane keypad on the scanner's scan/sense
// lines. A press request latches the key's row/column, closes the
// contact for HOLD_CYCLES, then keeps it open for GAP_CYCLES before the
// next request is accepted. Define KEYPAD_EMU_BOUNCE_EN to add
// LFSR-driven bounce-in/bounce-out windows of BOUNCE_CYCLES each.
module keypad_matrix_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES   = 1000,
    parameter int BOUNCE_CYCLES = 16,
    parameter int GAP_CYCLES    = 64,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       press_req,
    output logic       press_ready,
    output logic       busy,
    output logic       done,
    input  logic [3:0] scan_in,
    output logic [3:0] sense_out
);

    localparam logic [2:0] S_IDLE = EMU_IDLE;
    localparam logic [2:0] S_HOLD = EMU_HOLD;
    localparam logic [2:0] S_GAP  = EMU_GAP;

    localparam logic [CNT_W-1:0] LAST_HOLD = CNT_W'(last_index(HOLD_CYCLES));
    localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'(last_index(GAP_CYCLES));

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic [2:0] S_BOUNCE_IN  = EMU_BOUNCE_IN;
    localparam logic [2:0] S_BOUNCE_OUT = EMU_BOUNCE_OUT;
    localparam logic [2:0] S_AFTER_IDLE = S_BOUNCE_IN;
    localparam logic [2:0] S_AFTER_HOLD = S_BOUNCE_OUT;
    localparam logic [CNT_W-1:0] LAST_BOUNCE = CNT_W'(last_index(BOUNCE_CYCLES));
`else
    localparam logic [2:0] S_AFTER_IDLE = S_HOLD;
    localparam logic [2:0] S_AFTER_HOLD = S_GAP;
    // Bounce length has no meaning without the bounce windows
    logic unused_bounce_cfg;
    assign unused_bounce_cfg = ^BOUNCE_CYCLES;
`endif

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       row_q;
    logic [1:0]       col_q;
    logic             accept;
    logic             contact;
    logic             bounce_bit;
    logic [3:0]       sense_p1;
    rowcol_t          key_rc;

    assign accept = (state == S_IDLE) && press_req;
    assign key_rc = key_to_rowcol(key_code);

`ifdef KEYPAD_EMU_BOUNCE_EN
    lfsr8_bounce u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .en      ((state == S_BOUNCE_IN) || (state == S_BOUNCE_OUT)),
        .seed    (LFSR_SEED),
        .bit_out (bounce_bit)
    );
`else
    assign bounce_bit = 1'b0;
`endif

    // Phase sequencing: each phase ends when the shared counter hits its last index
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (accept)             state_nxt = S_AFTER_IDLE;
`ifdef KEYPAD_EMU_BOUNCE_EN
            S_BOUNCE_IN:  if (cnt == LAST_BOUNCE) state_nxt = S_HOLD;
            S_BOUNCE_OUT: if (cnt == LAST_BOUNCE) state_nxt = S_GAP;
`endif
            S_HOLD:       if (cnt == LAST_HOLD)   state_nxt = S_AFTER_HOLD;
            S_GAP:        if (cnt == LAST_GAP)    state_nxt = S_IDLE;
            default:                              state_nxt = S_IDLE;
        endcase
    end

    // State register and phase counter, cleared on every state entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if ((state_nxt != state) || (state == S_IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Capture the key position at acceptance; ignored for the rest of the press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= 2'd0;
            col_q <= 2'd0;
        end else if (accept) begin
            row_q <= key_rc.row;
            col_q <= key_rc.col;
        end
    end

    // Contact level: closed in HOLD, pseudo-random while bouncing, open otherwise
    always_comb begin
        contact = 1'b0;
        case (state)
            S_HOLD:       contact = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            S_BOUNCE_IN,
            S_BOUNCE_OUT: contact = bounce_bit;
`endif
            default:      contact = 1'b0;
        endcase
    end

    // ---- stage p1: registered column sense answering the current row scan ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sense_p1 <= IDLE_LINES;
        end else if (contact && (scan_in == row_pattern(row_q))) begin
            sense_p1 <= col_pattern(col_q);
        end else begin
            sense_p1 <= IDLE_LINES;
        end
    end

    assign sense_out   = sense_p1;
    assign press_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_GAP) && (cnt == LAST_GAP);

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed bench for keypad_matrix_emulator (HOLD=10, GAP=4, BOUNCE=16).
// Without KEYPAD_EMU_BOUNCE_EN the exact-timing press scenarios run;
// with it, the bounce sequence and its repeatability after reset run.
module tb_keypad_matrix_emulator;

    localparam int HOLD   = 10;
    localparam int GAP    = 4;
    localparam int BOUNCE = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_code = 4'h0;
    logic       press_req = 1'b0;
    logic       press_ready;
    logic       busy;
    logic       done;
    logic [3:0] scan_in = 4'hF;
    logic [3:0] sense_out;

    int total = 0;
    int bad   = 0;

    keypad_matrix_emulator #(
        .HOLD_CYCLES   (HOLD),
        .BOUNCE_CYCLES (BOUNCE),
        .GAP_CYCLES    (GAP),
        .CNT_W         (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_code    (key_code),
        .press_req   (press_req),
        .press_ready (press_ready),
        .busy        (busy),
        .done        (done),
        .scan_in     (scan_in),
        .sense_out   (sense_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (press_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk(tag, {7'd0, press_ready}, 8'd1);
    endtask

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int SEQ_N = 2 * BOUNCE + HOLD + 2;
    logic [3:0] exp_seq [SEQ_N];
    logic [3:0] run1    [SEQ_N];

    task automatic bounce_press(input int run);
        key_code  = 4'hA;
        scan_in   = 4'b0111;
        press_req = 1'b1;
        step();
        press_req = 1'b0;
        for (int k = 0; k < SEQ_N; k++) begin
            step();
            chk($sformatf("bounce_r%0d_k%0d", run, k), {4'd0, sense_out}, {4'd0, exp_seq[k]});
            if (run == 1) run1[k] = sense_out;
            else chk($sformatf("repeat_k%0d", k), {4'd0, sense_out}, {4'd0, run1[k]});
        end
        wait_idle($sformatf("bounce_idle_r%0d", run));
    endtask
`endif

    initial begin
`ifdef KEYPAD_EMU_BOUNCE_EN
        logic [7:0] m;
        int         toggles;
`else
        int         done_hits;
`endif
        // Reset state
        repeat (3) step();
        chk("rst_ready", {7'd0, press_ready}, 8'd1);
        chk("rst_busy",  {7'd0, busy},        8'd0);
        chk("rst_done",  {7'd0, done},        8'd0);
        chk("rst_sense", {4'd0, sense_out},   8'h0F);
        rst = 1'b0;
        step();

`ifdef KEYPAD_EMU_BOUNCE_EN
        // Expected sense for key A (row0, col3 -> 1110) under scan 0111
        m = 8'hA5;
        for (int k = 0; k < SEQ_N; k++) begin
            if (k < BOUNCE || (k >= BOUNCE + HOLD && k < 2 * BOUNCE + HOLD)) begin
                exp_seq[k] = m[7] ? 4'b1110 : 4'hF;
                m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
            end else if (k < BOUNCE + HOLD) begin
                exp_seq[k] = 4'b1110;
            end else begin
                exp_seq[k] = 4'hF;
            end
        end
        bounce_press(1);
        toggles = 0;
        for (int k = 1; k < BOUNCE; k++) if (run1[k] != run1[k-1]) toggles++;
        chk("bounce_toggles", {7'd0, toggles > 0}, 8'd1);
        // Reset reseeds the LFSR, so the sequence must repeat exactly
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        bounce_press(2);
`else
        // 1: key 5 (row1 col1), rotating scan then steady scan on row1
        key_code  = 4'h5;
        press_req = 1'b1;
        step();
        press_req = 1'b0;
        chk("t1_busy",      {7'd0, busy},        8'd1);
        chk("t1_ready",     {7'd0, press_ready}, 8'd0);
        chk("t1_sense_acc", {4'd0, sense_out},   8'h0F);
        scan_in = 4'b0111; step(); chk("t1_row0", {4'd0, sense_out}, 8'h0F);
        scan_in = 4'b1011; step(); chk("t1_row1", {4'd0, sense_out}, 8'h0B);
        scan_in = 4'b1101; step(); chk("t1_row2", {4'd0, sense_out}, 8'h0F);
        scan_in = 4'b1110; step(); chk("t1_row3", {4'd0, sense_out}, 8'h0F);
        scan_in = 4'b1011;
        for (int i = 5; i <= 10; i++) begin
            step();
            chk($sformatf("t1_hold_%0d", i), {4'd0, sense_out}, 8'h0B);
        end
        for (int i = 11; i <= 14; i++) begin
            step();
            chk($sformatf("t1_gap_sense_%0d", i), {4'd0, sense_out}, 8'h0F);
            chk($sformatf("t1_done_%0d", i), {7'd0, done}, {7'd0, i == 13});
        end
        chk("t1_ready_end", {7'd0, press_ready}, 8'd1);

        // 2: keys E and D with scan on row3
        key_code = 4'hE; scan_in = 4'b1110; press_req = 1'b1;
        step(); press_req = 1'b0;
        chk("t2_e_acc", {4'd0, sense_out}, 8'h0F);
        step(); chk("t2_e", {4'd0, sense_out}, 8'h07);
        wait_idle("t2_e_idle");
        key_code = 4'hD; press_req = 1'b1;
        step(); press_req = 1'b0;
        step(); chk("t2_d", {4'd0, sense_out}, 8'h0E);
        wait_idle("t2_d_idle");

        // 3: press_req held high, key_code changed mid-press
        key_code = 4'h2; scan_in = 4'b0111; press_req = 1'b1;
        step();
        chk("t3_busy_0", {7'd0, busy}, 8'd1);
        key_code = 4'h9;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("t3_busy_%0d", i),  {7'd0, busy},        {7'd0, i != 14});
            chk($sformatf("t3_done_%0d", i),  {7'd0, done},        {7'd0, i == 13});
            chk($sformatf("t3_ready_%0d", i), {7'd0, press_ready}, {7'd0, i == 14});
            if (i == 2) chk("t3_key_ignored", {4'd0, sense_out}, 8'h0B);
        end
        press_req = 1'b0;
        scan_in   = 4'b1101;
        step(); chk("t3_second_key", {4'd0, sense_out}, 8'h0D);
        wait_idle("t3_idle");

        // 4: malformed scans during HOLD for key 1 (row0 col0)
        key_code = 4'h1; scan_in = 4'b0011; press_req = 1'b1;
        step(); press_req = 1'b0;
        step(); chk("t4_0011", {4'd0, sense_out}, 8'h0F);
        scan_in = 4'b1111; step(); chk("t4_1111", {4'd0, sense_out}, 8'h0F);
        scan_in = 4'b0111; step(); chk("t4_0111", {4'd0, sense_out}, 8'h07);
        scan_in = 4'b0000; step(); chk("t4_0000", {4'd0, sense_out}, 8'h0F);
        wait_idle("t4_idle");

        // 5: asynchronous reset in the middle of HOLD
        key_code = 4'h1; scan_in = 4'b0111; press_req = 1'b1;
        step(); press_req = 1'b0;
        repeat (3) step();
        chk("t5_pre", {4'd0, sense_out}, 8'h07);
        rst = 1'b1;
        #1;
        chk("t5_sense", {4'd0, sense_out},   8'h0F);
        chk("t5_ready", {7'd0, press_ready}, 8'd1);
        chk("t5_busy",  {7'd0, busy},        8'd0);
        chk("t5_done",  {7'd0, done},        8'd0);
        step();
        rst = 1'b0;
        done_hits = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1 || sense_out !== 4'hF) done_hits++;
        end
        chk("t5_quiet", done_hits[7:0], 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
